display_timing_gen: RTL
=======================

DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 24, horizontal front porch clocks.
REQ-003 SHALL have parameter H_SYNC, default 136, horizontal sync width clocks.
REQ-004 SHALL have parameter H_BP, default 144, horizontal back porch clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 3, vertical front porch lines.
REQ-007 SHALL have parameter V_SYNC, default 6, vertical sync width lines.
REQ-008 SHALL have parameter V_BP, default 29, vertical back porch lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, asserted level of horiz_sync and vert_sync (0 = active-low).
REQ-010 SHALL have port clk  input  1  pixel clock (75 MHz in the 1024x768 build); one clock; the only clock.
REQ-011 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-012 SHALL have port pixel_column  output  12  current horizontal count, 0..H_TOTAL-1.
REQ-013 SHALL have port pixel_row  output  12  current vertical count, 0..V_TOTAL-1.
REQ-014 SHALL have port video_on  output  1  high only inside the visible region.
REQ-015 SHALL have port horiz_sync  output  1  horizontal sync to the VGA connector.
REQ-016 SHALL have port vert_sync  output  1  vertical sync to the VGA connector.
REQ-017 SHALL have port frame_start  output  1  one-clock pulse at pixel (0,0).
REQ-018 SHALL have port frame_count  output  16  frame counter for animation and title timing.

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1328) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806); both SHALL be <= 4096.
REQ-020 SHALL advance pixel_column by 1 every clock; at H_TOTAL-1 it SHALL wrap to 0 on the next clock.
REQ-021 SHALL advance pixel_row by 1 only on a clock where pixel_column wraps; at V_TOTAL-1 with column wrap, both SHALL become 0.
REQ-022 SHALL drive every output from a register; all outputs SHALL describe the same (column,row) pair on every cycle (zero skew between counters and decodes).
REQ-023 SHALL assert video_on iff pixel_column < H_ACTIVE and pixel_row < V_ACTIVE.
REQ-024 SHALL drive horiz_sync to SYNC_POL iff H_ACTIVE+H_FP <= pixel_column < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
REQ-025 SHALL drive vert_sync to SYNC_POL iff V_ACTIVE+V_FP <= pixel_row < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL (full lines, not pixel-offset).
REQ-026 SHALL assert frame_start for exactly the one cycle in which (pixel_column,pixel_row) = (0,0).
REQ-027 SHALL increment frame_count (mod 2^16) on the same edge that frame_start rises; 16'hFFFF SHALL wrap to 16'h0000.

Reset
REQ-028 SHALL, on any clk edge with rstn low, load pixel_column = H_TOTAL-1, pixel_row = V_TOTAL-1, video_on = 0, horiz_sync = vert_sync = ~SYNC_POL, frame_start = 0, frame_count = 16'hFFFF.
REQ-029 SHALL, on the first edge with rstn high, present (0,0), video_on = 1, frame_start = 1, frame_count = 16'h0000.
REQ-030 SHALL, when rstn falls mid-frame, reach the REQ-028 state at that edge with no partial line or extra frame_start.

Verification
REQ-031 Release reset -> next cycle column 0, row 0, video_on 1, frame_start 1, frame_count 0; frame_start next high exactly 1,070,368 clocks later with frame_count 1.
REQ-032 Row 0 sweep -> video_on high columns 0..1023, low 1024..1327; horiz_sync low exactly columns 1048..1183 (136 clocks), high elsewhere.
REQ-033 Full frame -> vert_sync low exactly rows 771..776 (6x1328 clocks), asserting at column 0 of row 771; video_on 0 on all rows 768..805.
REQ-034 Counter wrap -> column 1327 followed by column 0 with row +1; row 805/column 1327 followed by (0,0) and frame_start.
REQ-035 Force frame_count near wrap (run 65536 frames or parameter-shrunk totals, e.g. H_TOTAL=8,V_TOTAL=4) -> frame_count 16'hFFFF followed by 16'h0000 at frame_start.
REQ-036 Assert rstn low at row 400 column 500 for 3 clocks -> outputs equal REQ-028 values during reset; first cycle after release matches REQ-029.

Source files
------------

// File: rtl/display_timing_gen.sv
// Raster timing generator: pixel/line counters with registered video, sync and frame decodes.
// Latency: every output is a register holding the decode of the same (column,row) pair.
// Backpressure: none; free-running, advances one pixel per clk.
module display_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 144,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [11:0] pixel_column,
  output logic [11:0] pixel_row,
  output logic        video_on,
  output logic        horiz_sync,
  output logic        vert_sync,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  // Totals must fit the 12-bit counters (<= 4096).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Decode boundaries are 13 bits wide so a sync window ending at 4096 still compares correctly.
  localparam logic [12:0] H_VIS_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_VIS_END  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] col_nxt;
  logic [11:0] row_nxt;
  logic        video_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        fs_nxt;
  logic        col_wrap;

  // Next pixel position and its decodes, so the registers all update to one coherent pair.
  always_comb begin
    col_wrap  = (pixel_column == H_LAST);
    col_nxt   = col_wrap ? 12'd0 : pixel_column + 12'd1;
    row_nxt   = pixel_row;
    if (col_wrap) begin
      row_nxt = (pixel_row == V_LAST) ? 12'd0 : pixel_row + 12'd1;
    end
    video_nxt = ({1'b0, col_nxt} < H_VIS_END) && ({1'b0, row_nxt} < V_VIS_END);
    hs_nxt    = (({1'b0, col_nxt} >= H_SYNC_BEG) && ({1'b0, col_nxt} < H_SYNC_END))
                ? SYNC_POL : ~SYNC_POL;
    vs_nxt    = (({1'b0, row_nxt} >= V_SYNC_BEG) && ({1'b0, row_nxt} < V_SYNC_END))
                ? SYNC_POL : ~SYNC_POL;
    fs_nxt    = (col_nxt == 12'd0) && (row_nxt == 12'd0);
  end

  // Reset parks on the last pixel of the frame so the first free-running edge lands on (0,0).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pixel_column <= H_LAST;
      pixel_row    <= V_LAST;
      video_on     <= 1'b0;
      horiz_sync   <= ~SYNC_POL;
      vert_sync    <= ~SYNC_POL;
      frame_start  <= 1'b0;
      frame_count  <= 16'hFFFF;
    end else begin
      pixel_column <= col_nxt;
      pixel_row    <= row_nxt;
      video_on     <= video_nxt;
      horiz_sync   <= hs_nxt;
      vert_sync    <= vs_nxt;
      frame_start  <= fs_nxt;
      if (fs_nxt) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
